// File: rtl/loader_pkg.sv
// Shared types and default geometry for the serial dataset loader.
package loader_pkg;

  localparam int unsigned LOADER_WORD_W       = 16;
  localparam int unsigned LOADER_MAX_FEATURES = 15;
  localparam int unsigned LOADER_ROW_W        = (LOADER_MAX_FEATURES + 1) * LOADER_WORD_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_e;

endpackage

// File: rtl/serial_word_deser.sv
// Serial-to-parallel word assembler, LANES bits per beat, LSB first.
// With LOADER_PARITY_EN an extra even-parity beat (lane 0) follows each word.
module serial_word_deser
  import loader_pkg::*;
#(
  parameter int unsigned WORD_W = LOADER_WORD_W,
  parameter int unsigned LANES  = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [LANES-1:0]  lanes_i,
  output logic [WORD_W-1:0] word_o,
  output logic              done_o,
  output logic              par_err_o
);

  localparam int unsigned BEATS = WORD_W / LANES;
`ifdef LOADER_PARITY_EN
  localparam int unsigned LAST  = BEATS;
`else
  localparam int unsigned LAST  = BEATS - 1;
`endif
  localparam int unsigned CNT_W = $clog2(BEATS + 2);

  logic [CNT_W-1:0]  beat_q, beat_d;
  logic [WORD_W-1:0] sr_q, sr_d;

  always_comb begin
    beat_d    = beat_q;
    sr_d      = sr_q;
    done_o    = 1'b0;
    par_err_o = 1'b0;
    if (clr_i) begin
      beat_d = '0;
      sr_d   = '0;
    end else if (en_i) begin
      for (int unsigned b = 0; b < BEATS; b++) begin
        if (beat_q == CNT_W'(b)) sr_d[b*LANES +: LANES] = lanes_i;
      end
      if (beat_q == CNT_W'(LAST)) begin
        done_o = 1'b1;
        beat_d = '0;
`ifdef LOADER_PARITY_EN
        par_err_o = (lanes_i[0] != ^sr_q);
`endif
      end else begin
        beat_d = beat_q + CNT_W'(1);
      end
    end
  end

  // Word includes the beat arriving this cycle, so the caller can store it at this edge.
  assign word_o = sr_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_q <= '0;
      sr_q   <= '0;
    end else begin
      beat_q <= beat_d;
      sr_q   <= sr_d;
    end
  end

endmodule

// File: rtl/serial_dataset_loader.sv
// Loads data_points rows of feat+1 serial words each into a parallel row buffer.
// Optional parity checking is enabled with LOADER_PARITY_EN.
module serial_dataset_loader
  import loader_pkg::*;
#(
  parameter int unsigned WORD_W       = LOADER_WORD_W,
  parameter int unsigned MAX_FEATURES = LOADER_MAX_FEATURES,
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned LANES        = 1
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              start,
  input  logic [3:0]                        feat,
  input  logic [ADDR_WIDTH-1:0]             data_points,
  input  logic                              s_valid,
  input  logic [LANES-1:0]                  s_data,
  output logic                              row_valid,
  output logic [ADDR_WIDTH-1:0]             row_addr,
  output logic [(MAX_FEATURES+1)*WORD_W-1:0] row_data,
  output logic                              busy,
  output logic                              done,
  output logic                              err
);

  localparam int unsigned ROW_BITS = (MAX_FEATURES + 1) * WORD_W;

  loader_state_e         state_q, state_d;
  logic [3:0]            feat_q, feat_d, col_q, col_d;
  logic [ADDR_WIDTH-1:0] npts_q, npts_d, row_q, row_d, raddr_q, raddr_d;
  logic [ROW_BITS-1:0]   rowbuf_q, rowbuf_d, rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d, err_q, err_d;
  logic                  deser_clr, deser_en, word_done, par_err;
  logic [WORD_W-1:0]     word;

  assign deser_en  = s_valid && (state_q == LOAD);
  assign deser_clr = start && (state_q != LOAD);

  serial_word_deser #(
    .WORD_W (WORD_W),
    .LANES  (LANES)
  ) u_deser (
    .clk_i     (CLK),
    .rst_i     (RST),
    .clr_i     (deser_clr),
    .en_i      (deser_en),
    .lanes_i   (s_data),
    .word_o    (word),
    .done_o    (word_done),
    .par_err_o (par_err)
  );

  always_comb begin
    state_d  = state_q;
    feat_d   = feat_q;
    npts_d   = npts_q;
    row_d    = row_q;
    col_d    = col_q;
    rowbuf_d = rowbuf_q;
    rdata_d  = rdata_q;
    raddr_d  = raddr_q;
    rvalid_d = 1'b0;
    err_d    = err_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          feat_d   = feat;
          npts_d   = data_points;
          row_d    = '0;
          col_d    = feat;
          err_d    = 1'b0;
          rowbuf_d = '0;
          state_d  = (data_points == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (word_done) begin
          if (par_err) err_d = 1'b1;
          for (int unsigned c = 0; c <= MAX_FEATURES; c++) begin
            if (col_q == 4'(c)) rowbuf_d[c*WORD_W +: WORD_W] = word;
          end
          // Column 0 is last: publish the merged row and restart the buffer.
          if (col_q == 4'd0) begin
            rvalid_d = 1'b1;
            raddr_d  = row_q;
            rdata_d  = rowbuf_d;
            rowbuf_d = '0;
            col_d    = feat_q;
            row_d    = row_q + ADDR_WIDTH'(1);
            if (row_q == npts_q - ADDR_WIDTH'(1)) state_d = DONE;
          end else begin
            col_d = col_q - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      feat_q   <= '0;
      npts_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
      rowbuf_q <= '0;
      rdata_q  <= '0;
      raddr_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      feat_q   <= feat_d;
      npts_q   <= npts_d;
      row_q    <= row_d;
      col_q    <= col_d;
      rowbuf_q <= rowbuf_d;
      rdata_q  <= rdata_d;
      raddr_q  <= raddr_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  assign row_valid = rvalid_q;
  assign row_addr  = raddr_q;
  assign row_data  = rdata_q;
  assign busy      = (state_q == LOAD);
  assign done      = (state_q == DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_serial_dataset_loader.sv
// Randomized bench for serial_dataset_loader: 1-lane and 4-lane instances against a row-level model.
module tb_serial_dataset_loader;

  localparam int unsigned W = 16;
`ifdef LOADER_PARITY_EN
  localparam int unsigned PB = W + 1;
`else
  localparam int unsigned PB = W;
`endif

  typedef struct {
    bit          l4;
    int unsigned stamp;
    logic [11:0] addr;
    logic [255:0] data;
  } row_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst, start_r, sv_r, sel4;
  logic [3:0]  feat_r, sd4_r;
  logic [11:0] npts_r;
  logic        rv1, rv4, busy1, busy4, done1, done4, err1, err4;
  logic [11:0] ra1, ra4;
  logic [255:0] rd1, rd4;

  serial_dataset_loader u_l1 (
    .CLK(clk), .RST(rst), .start(start_r & ~sel4), .feat(feat_r), .data_points(npts_r),
    .s_valid(sv_r & ~sel4), .s_data(sd4_r[0]), .row_valid(rv1), .row_addr(ra1),
    .row_data(rd1), .busy(busy1), .done(done1), .err(err1)
  );

  serial_dataset_loader #(.LANES(4)) u_l4 (
    .CLK(clk), .RST(rst), .start(start_r & sel4), .feat(feat_r), .data_points(npts_r),
    .s_valid(sv_r & sel4), .s_data(sd4_r), .row_valid(rv4), .row_addr(ra4),
    .row_data(rd4), .busy(busy4), .done(done4), .err(err4)
  );

  row_t        mon_q[$], exp_q[$];
  int unsigned n_checks = 0, n_pass = 0;
  int unsigned last_stamp, start_stamp;
  logic [15:0] w [16];
  logic [255:0] last_row;

  always @(negedge clk) begin
    if (rv1) mon_q.push_back('{1'b0, cyc, ra1, rd1});
    if (rv4) mon_q.push_back('{1'b1, cyc, ra4, rd4});
  end

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag, input logic b, input logic d, input logic e);
    check_eq({tag, "_busy"}, sel4 ? busy4 : busy1, b);
    check_eq({tag, "_done"}, sel4 ? done4 : done1, d);
    check_eq({tag, "_err"},  sel4 ? err4  : err1,  e);
  endtask

  task automatic do_start(input bit l4, input logic [3:0] f, input logic [11:0] n);
    sel4 = l4; start_r = 1'b1; feat_r = f; npts_r = n;
    start_stamp = cyc + 1;
    tick();
    start_r = 1'b0;
  endtask

  task automatic send_word(input bit l4, input logic [15:0] wd, input int unsigned gap_at,
                           input int unsigned gap_len, input bit bad_par);
    int unsigned lanes = l4 ? 4 : 1;
    for (int unsigned b = 0; b < W / lanes; b++) begin
      if (b == gap_at) begin
        sv_r = 1'b0;
        repeat (gap_len) tick();
      end
      sv_r  = 1'b1;
      sd4_r = l4 ? wd[b*4 +: 4] : {3'b000, wd[b]};
      last_stamp = cyc + 1;
      tick();
    end
`ifdef LOADER_PARITY_EN
    sv_r  = 1'b1;
    sd4_r = {3'b101, (^wd) ^ bad_par};
    last_stamp = cyc + 1;
    tick();
`else
    if (bad_par) sd4_r = 4'h0;
`endif
    sv_r = 1'b0;
  endtask

  // Words go out feat..0; word i lands in column feat-i. Row is seen the cycle the last beat lands.
  task automatic send_row(input bit l4, input int unsigned f, input logic [11:0] addr,
                          input logic [15:0] wv [16], input int unsigned gap_word,
                          input int unsigned gap_beat, input int unsigned gap_len, input bit bad_par);
    row_t e;
    logic [255:0] row = '0;
    for (int unsigned i = 0; i <= f; i++) begin
      row[(f-i)*16 +: 16] = wv[i];
      send_word(l4, wv[i], (i == gap_word) ? gap_beat : 99, gap_len, bad_par);
    end
    e.l4 = l4; e.stamp = last_stamp; e.addr = addr; e.data = row;
    exp_q.push_back(e);
  endtask

  task automatic check_rows(input string tag);
    row_t m, e;
    check_eq({tag, "_rows"}, mon_q.size(), exp_q.size());
    while (mon_q.size() > 0 && exp_q.size() > 0) begin
      m = mon_q.pop_front();
      e = exp_q.pop_front();
      check_eq({tag, "_lane"},  m.l4,    e.l4);
      check_eq({tag, "_stamp"}, m.stamp, e.stamp);
      check_eq({tag, "_addr"},  m.addr,  e.addr);
      check_eq({tag, "_data"},  m.data,  e.data);
    end
    mon_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; start_r = 1'b0; sv_r = 1'b0; sel4 = 1'b0;
    feat_r = '0; sd4_r = '0; npts_r = '0;
    tick(); tick();
    check_eq("rst_rv1", rv1, 1'b0);
    check_eq("rst_ra1", ra1, 12'd0);
    check_eq("rst_rd1", rd1, '0);
    check_eq("rst_rd4", rd4, '0);
    check_status("rst", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();

    // 1 lane, 12 words per row, 4 rows; stray start mid-run must be ignored
    for (int unsigned i = 0; i < 12; i++) w[i] = 16'(i + 1);
    do_start(1'b0, 4'd11, 12'd4);
    check_status("s1_start", 1'b1, 1'b0, 1'b0);
    for (int unsigned r = 0; r < 4; r++) begin
      if (r == 2) begin
        start_r = 1'b1; feat_r = 4'd3; npts_r = 12'd1;
        tick();
        start_r = 1'b0;
      end
      send_row(1'b0, 11, 12'(r), w, 99, 0, 0, 1'b0);
    end
    last_row = exp_q[exp_q.size()-1].data;
    check_eq("s1_col11", last_row[11*16 +: 16], 16'h0001);
    check_eq("s1_rv_last", rv1, 1'b1);
    check_status("s1_end", 1'b0, 1'b1, 1'b0);
    tick();
    check_eq("s1_rv_pulse", rv1, 1'b0);
    check_eq("s1_hold", rd1, last_row);
    check_rows("s1");

    // 4 lanes, one word per row, back to back
    w[0] = 16'hA5A5;
    do_start(1'b1, 4'd0, 12'd2);
    send_row(1'b1, 0, 12'd0, w, 99, 0, 0, 1'b0);
    w[0] = 16'h1234;
    send_row(1'b1, 0, 12'd1, w, 99, 0, 0, 1'b0);
    check_status("s2_end", 1'b0, 1'b1, 1'b0);
    tick();
    check_eq("s2_spacing", exp_q[1].stamp - exp_q[0].stamp, (PB == W) ? 4 : 5);
    check_rows("s2");

    // 3-cycle gap inside a word
    w[0] = 16'($urandom); w[1] = 16'($urandom);
    do_start(1'b0, 4'd1, 12'd1);
    send_row(1'b0, 1, 12'd0, w, 0, 8, 3, 1'b0);
    check_eq("s3_gap_latency", last_stamp - start_stamp, 2 * PB + 3);
    tick();
    check_rows("s3");

    // random configurations on both lane widths
    for (int it = 0; it < 4; it++) begin
      bit          l4 = 1'($urandom_range(0, 1));
      int unsigned f  = $urandom_range(0, 15);
      int unsigned n  = $urandom_range(1, 3);
      do_start(l4, 4'(f), 12'(n));
      for (int unsigned r = 0; r < n; r++) begin
        for (int unsigned i = 0; i < 16; i++) w[i] = 16'($urandom);
        send_row(l4, f, 12'(r), w, $urandom_range(0, f), $urandom_range(0, 3),
                 $urandom_range(0, 3), 1'b0);
      end
      check_status("rnd_end", 1'b0, 1'b1, 1'b0);
      tick();
      check_rows("rnd");
    end

    // reset mid-row aborts; reset beats a simultaneous start
    for (int unsigned i = 0; i < 16; i++) w[i] = 16'($urandom);
    do_start(1'b0, 4'd2, 12'd3);
    send_row(1'b0, 2, 12'd0, w, 99, 0, 0, 1'b0);
    send_word(1'b0, w[3], 99, 0, 1'b0);
    sv_r = 1'b1; sd4_r = 4'h1;
    tick(); tick();
    sv_r = 1'b0; rst = 1'b1;
    tick();
    start_r = 1'b1; npts_r = 12'd2; feat_r = 4'd0;
    tick();
    rst = 1'b0; start_r = 1'b0;
    check_eq("s5_rd", rd1, '0);
    check_eq("s5_ra", ra1, 12'd0);
    check_status("s5_rst", 1'b0, 1'b0, 1'b0);
    tick(); tick();
    check_rows("s5_abort");
    do_start(1'b0, 4'd0, 12'd1);
    send_row(1'b0, 0, 12'd0, w, 99, 0, 0, 1'b0);
    check_status("s5_end", 1'b0, 1'b1, 1'b0);
    tick();
    check_rows("s5_new");

    // zero data points
    do_start(1'b0, 4'd5, 12'd0);
    check_status("s6_start", 1'b0, 1'b1, 1'b0);
    tick();
    check_status("s6_next", 1'b0, 1'b1, 1'b0);
    check_rows("s6");

`ifdef LOADER_PARITY_EN
    // bad parity on 0x0003 sets err, row still written, next start clears
    w[0] = 16'h0003;
    do_start(1'b0, 4'd0, 12'd1);
    send_row(1'b0, 0, 12'd0, w, 99, 0, 0, 1'b1);
    check_status("s7_bad", 1'b0, 1'b1, 1'b1);
    tick();
    check_rows("s7_bad");
    do_start(1'b0, 4'd0, 12'd1);
    check_status("s7_clr", 1'b1, 1'b0, 1'b0);
    send_row(1'b0, 0, 12'd0, w, 99, 0, 0, 1'b0);
    check_status("s7_good", 1'b0, 1'b1, 1'b0);
    tick();
    check_rows("s7_good");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_dataset_loader.md
SERIAL_DATASET_LOADER -- requirements
Module: serial_dataset_loader

Interface
REQ-001 SHALL have parameter WORD_W, default 16: bits per serial word.
REQ-002 SHALL have parameter MAX_FEATURES, default 15: maximum feature count; a row holds MAX_FEATURES+1 words, including y.
REQ-003 SHALL have parameter ADDR_WIDTH, default 12: width of the data-point count and row address.
REQ-004 SHALL have parameter LANES, default 1 (legal values 1, 2, 4; WORD_W mod LANES == 0): number of serial bits per beat.
REQ-005 SHALL have port CLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: single-cycle strobe that latches the configuration and arms loading.
REQ-008 SHALL have port feat, input, 4 bits: feature count for the run; each row carries feat+1 words.
REQ-009 SHALL have port data_points, input, ADDR_WIDTH bits: number of rows to load.
REQ-010 SHALL have port s_valid, input, 1 bit: qualifies s_data for the current beat.
REQ-011 SHALL have port s_data, input, LANES bits: serial payload for the current beat.
REQ-012 SHALL have port row_valid, output, 1 bit: one-cycle pulse; the assembled row is valid.
REQ-013 SHALL have port row_addr, output, ADDR_WIDTH bits: index of the row being written.
REQ-014 SHALL have port row_data, output, (MAX_FEATURES+1)*WORD_W bits: assembled row.
REQ-015 SHALL have ports busy, done and err, outputs, 1 bit each: loading in progress; all rows loaded; parity error seen.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD and DONE; start in IDLE or DONE SHALL enter LOAD, or DONE directly if data_points==0.
REQ-017 SHALL latch feat and data_points on start, and SHALL clear the row counter, the beat counter and err; the column counter SHALL be set to the latched feat.
REQ-018 SHALL ignore start while in LOAD, and SHALL ignore s_valid while in IDLE or DONE.
REQ-019 SHALL, on each s_valid beat, place lane k into word bit (beat*LANES+k), LSB first; a word completes after WORD_W/LANES valid beats, and gaps in s_valid SHALL stall without loss.
REQ-020 SHALL send words in descending column order, feat down to 0; a completed word SHALL be stored at row_data[col*WORD_W +: WORD_W], and columns above feat SHALL read 0.
REQ-021 SHALL assert row_valid for one cycle, in the cycle after the final beat of column 0, with row_addr equal to the current row; the row buffer SHALL then clear for the next row.
REQ-022 SHALL move from LOAD to DONE in the same cycle as the row_valid of row data_points-1; done SHALL be 1 in DONE only.
REQ-023 SHALL drive busy=1 only in LOAD.
REQ-024 SHALL handle feat==0 as one word per row.
REQ-025 SHALL allow back-to-back rows with no idle beat between them.
REQ-026 SHALL hold row_data stable until the next row_valid.

Reset
REQ-027 SHALL, when RST=1 at a clock edge, go to IDLE and set row_valid=0, row_addr=0, row_data=0, busy=0, done=0, err=0 and all counters to 0.
REQ-028 SHALL abort a load when RST occurs mid-load, with no row_valid generated for the partial row.
REQ-029 SHALL give RST priority over start in the same cycle.

Configuration
REQ-030 SHALL, with LOADER_PARITY_EN defined, expect one extra valid beat after each word, with lane 0 carrying even parity of the word and other lanes ignored; a mismatch SHALL set err sticky until the next start or RST, and the word SHALL still be stored.
REQ-031 SHALL, without LOADER_PARITY_EN, have no parity beat and tie err to 0.

Structure
REQ-032 SHALL place the FSM state enum, WORD_W and MAX_FEATURES defaults, and a ROW_W constant in shared package loader_pkg.
REQ-033 SHALL contain one sub-module, serial_word_deser (beat counter, shift register, optional parity check), instantiated once.

Verification
REQ-034 SHALL cover: LANES=1, feat=11, data_points=4, words 0x0001..0x000C per row, LSB first -> 4 row_valid pulses, row_addr 0..3, word at col 11 = first word sent, done=1 after the 4th pulse.
REQ-035 SHALL cover: LANES=4, feat=0, data_points=2, words 0xA5A5 and 0x1234 -> row_data[15:0] matches each, upper bits 0, each row_valid 4 beats after the previous one.
REQ-036 SHALL cover: s_valid deasserted for 3 cycles mid-word -> the word is reassembled unchanged and row_valid is delayed by exactly 3 cycles.
REQ-037 SHALL cover: RST during row 1 of 3, then a new start with data_points=1 -> no row_valid for the aborted row; the new run produces row_addr 0 and done.
REQ-038 SHALL cover: data_points=0 with start -> DONE next cycle, busy never 1, no row_valid.
REQ-039 SHALL cover: with LOADER_PARITY_EN, word 0x0003 followed by parity bit 1 -> err=1, the row is still written, and err clears on the next start.
